// File: rtl/seq_stream_buffer.sv
// seq_stream_buffer: query-symbol FIFO with auto terminator insertion and dual-entry pop
module seq_stream_buffer #(
    parameter int DATA_W   = 3,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 5,
    parameter int AF_LEVEL = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic [1:0]        pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] q0_o,
    output logic [DATA_W-1:0] q1_o,
    output logic              ready_one_o,
    output logic              ready_two_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              overflow_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_pend;
    logic              r_ovf;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_q0;
    logic [DATA_W-1:0] r_q1;
    logic              r_one;
    logic              r_two;
    logic              r_full;
    logic              r_af;

    logic [1:0]        w_pop_c;
    logic [CNT_W-1:0]  w_pop_eff;
    logic              w_push;
    logic              w_term;
    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    logic [CNT_W-1:0]  w_n_count;
    logic              w_n_pend;
    logic [PTR_W-1:0]  w_n_rptr;
    logic [PTR_W-1:0]  w_n_rptr1;
    logic [PTR_W-1:0]  w_n_wptr;
    logic [DATA_W-1:0] w_q0;
    logic [DATA_W-1:0] w_q1;

    // Pointer advance modulo DEPTH; amounts never exceed 2 so one subtract suffices
    function automatic logic [PTR_W-1:0] f_adv(input logic [PTR_W-1:0] p, input logic [1:0] a);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + {{PTR_W{1'b0}}, a};
        return (s >= (PTR_W+2)'(DEPTH)) ? PTR_W'(s - (PTR_W+2)'(DEPTH)) : PTR_W'(s);
    endfunction

    // Next-state: effective pop, push/terminator write, count and head entries from next storage
    always_comb begin
        w_pop_c   = (pop_i == 2'd3) ? 2'd2 : pop_i;
        w_pop_eff = (CNT_W'(w_pop_c) > r_count) ? r_count : CNT_W'(w_pop_c);
        w_push    = in_valid_i & r_in_ready;
        w_term    = r_pend & ((r_count < CNT_W'(DEPTH)) | (w_pop_eff != '0));
        w_wr      = w_push | w_term;
        w_wdata   = w_push ? in_data_i : '0;
        w_n_count = r_count + CNT_W'(w_wr) - w_pop_eff;
        w_n_pend  = (r_pend & ~w_term) | (w_push & in_last_i);
        w_n_rptr  = f_adv(r_rptr, w_pop_eff[1:0]);
        w_n_rptr1 = f_adv(w_n_rptr, 2'd1);
        w_n_wptr  = f_adv(r_wptr, {1'b0, w_wr});
        w_q0      = (w_n_count >= CNT_W'(1)) ? ((w_wr && w_n_rptr == r_wptr) ? w_wdata : r_mem[w_n_rptr]) : '0;
        w_q1      = (w_n_count >= CNT_W'(2)) ? ((w_wr && w_n_rptr1 == r_wptr) ? w_wdata : r_mem[w_n_rptr1]) : '0;
    end

    // Storage write; flush leaves contents untouched since pointers and count are cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!flush_i && w_wr) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // Control state and registered outputs, all derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_q0       <= '0;
            r_q1       <= '0;
            r_one      <= 1'b0;
            r_two      <= 1'b0;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
        end else if (flush_i) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_q0       <= '0;
            r_q1       <= '0;
            r_one      <= 1'b0;
            r_two      <= 1'b0;
            r_full     <= 1'b0;
            r_af       <= (AF_LEVEL <= 0);
        end else begin
            r_rptr     <= w_n_rptr;
            r_wptr     <= w_n_wptr;
            r_count    <= w_n_count;
            r_pend     <= w_n_pend;
            r_ovf      <= r_ovf | (CNT_W'(w_pop_c) > r_count);
            r_in_ready <= ~w_n_pend & (w_n_count < CNT_W'(DEPTH));
            r_q0       <= w_q0;
            r_q1       <= w_q1;
            r_one      <= w_n_count >= CNT_W'(1);
            r_two      <= w_n_count >= CNT_W'(2);
            r_full     <= w_n_count == CNT_W'(DEPTH);
            r_af       <= w_n_count >= CNT_W'(AF_LEVEL);
        end
    end

    assign in_ready_o    = r_in_ready;
    assign q0_o          = r_q0;
    assign q1_o          = r_q1;
    assign ready_one_o   = r_one;
    assign ready_two_o   = r_two;
    assign full_o        = r_full;
    assign almost_full_o = r_af;
    assign level_o       = r_count;
    assign overflow_o    = r_ovf;
endmodule

// File: tb/tb_seq_stream_buffer.sv
// tb_seq_stream_buffer: directed checks of push, dual pop, terminator, flush, overflow and reset
module tb_seq_stream_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid_i = 1'b0;
    logic [2:0] in_data_i = '0;
    logic       in_last_i = 1'b0;
    logic       in_ready_o;
    logic [1:0] pop_i = '0;
    logic       flush_i = 1'b0;
    logic [2:0] q0_o;
    logic [2:0] q1_o;
    logic       ready_one_o;
    logic       ready_two_o;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] level_o;
    logic       overflow_o;

    int n_chk = 0;
    int n_err = 0;

    seq_stream_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_last_i(in_last_i), .in_ready_o(in_ready_o), .pop_i(pop_i), .flush_i(flush_i),
        .q0_o(q0_o), .q1_o(q1_o), .ready_one_o(ready_one_o), .ready_two_o(ready_two_o),
        .full_o(full_o), .almost_full_o(almost_full_o), .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] d, input logic last);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        tick();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic pop(input logic [1:0] n);
        pop_i = n;
        tick();
        pop_i = 2'd0;
    endtask

    task automatic flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", in_ready_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_q0", q0_o, 0);
        chk("rst_flags", {ready_one_o, ready_two_o, full_o, almost_full_o, overflow_o}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready_o, 1);

        push(3'b101, 0);
        push(3'b110, 0);
        push(3'b111, 0);
        chk("three_q0", q0_o, 3'b101);
        chk("three_q1", q1_o, 3'b110);
        chk("three_level", level_o, 3);
        chk("three_rdy", {ready_one_o, ready_two_o}, 2'b11);
        pop(2'd3);
        chk("pop3_level", level_o, 1);
        chk("pop3_q0", q0_o, 3'b111);
        chk("pop3_q1", q1_o, 0);
        chk("pop3_ovf", overflow_o, 0);
        flush();

        for (int i = 0; i < 16; i++) begin
            push(3'(i) | 3'b100, 0);
            if (i == 12) chk("af_at13", almost_full_o, 0);
            if (i == 13) chk("af_at14", almost_full_o, 1);
            if (i == 14) chk("ready_at15", in_ready_o, 1);
        end
        chk("fill_full", full_o, 1);
        chk("fill_ready", in_ready_o, 0);
        chk("fill_level", level_o, 16);
        pop(2'd2);
        chk("pop2_level", level_o, 14);
        chk("pop2_ready", in_ready_o, 1);
        chk("pop2_full", full_o, 0);
        chk("pop2_q0", q0_o, 3'b110);
        chk("pop2_q1", q1_o, 3'b111);
        flush();

        push(3'b100, 1);
        chk("last_ready", in_ready_o, 0);
        chk("last_level1", level_o, 1);
        tick();
        chk("term_level", level_o, 2);
        chk("term_q0", q0_o, 3'b100);
        chk("term_q1", q1_o, 0);
        chk("term_ready", in_ready_o, 1);
        flush();

        for (int i = 0; i < 16; i++) push(3'(i) | 3'b100, i == 15);
        tick();
        chk("stall_level", level_o, 16);
        chk("stall_ready", in_ready_o, 0);
        pop(2'd1);
        chk("wrap_level", level_o, 16);
        chk("wrap_full", full_o, 1);
        chk("wrap_q0", q0_o, 3'b101);
        chk("wrap_ready", in_ready_o, 0);
        for (int i = 0; i < 7; i++) pop(2'd2);
        chk("drain_level", level_o, 2);
        chk("drain_q0", q0_o, 3'b111);
        chk("drain_q1", q1_o, 0);
        pop(2'd1);
        chk("last_term", {ready_one_o, q0_o}, {1'b1, 3'b000});
        chk("last_term_lvl", level_o, 1);
        pop(2'd2);
        chk("uf_level", level_o, 0);
        chk("uf_ovf", overflow_o, 1);
        tick();
        chk("uf_sticky", overflow_o, 1);
        flush();
        chk("flush_ovf", overflow_o, 0);
        chk("flush_level", level_o, 0);
        chk("flush_q0", q0_o, 0);
        chk("flush_ready", in_ready_o, 1);

        for (int i = 0; i < 7; i++) push(3'b101, i == 6);
        chk("mid_level", level_o, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level_o, 0);
        chk("mid_rst_q0", q0_o, 0);
        chk("mid_rst_ready", in_ready_o, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rel_ready", in_ready_o, 1);
        push(3'b110, 0);
        chk("rel_q0", q0_o, 3'b110);
        chk("rel_level", level_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
